// File: rtl/hcsr04_medida_ctrl.sv
// hcsr04_medida_ctrl: HC-SR04 trigger/echo sequencer feeding contador_cm and latching its BCD result
module hcsr04_medida_ctrl #(
  parameter int TRIG_CYCLES  = 500,
  parameter int ECHO_TIMEOUT = 1500000,
  parameter int CNT_W        = 21
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  input  logic        cm_pronto,
  input  logic [11:0] cm_bcd,
  output logic        trigger,
  output logic        pulso_cm,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout_err,
  output logic [3:0]  db_estado
);
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DISPARA     = 4'd1,
    ESPERA_ECHO = 4'd2,
    MEDINDO     = 4'd3,
    ARMAZENA    = 4'd4,
    FINAL       = 4'd5,
    ERRO        = 4'd15
  } estado_t;
  estado_t          estado, prox;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sync;
  logic             echo_s, fim_trig, fim_tempo;
  assign echo_s    = sync[1];
  assign fim_trig  = cnt == CNT_W'(TRIG_CYCLES - 1);
  assign fim_tempo = cnt == CNT_W'(ECHO_TIMEOUT - 1);
  // digits are captured alongside cm_pronto so they are valid throughout ARMAZENA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      cnt    <= '0;
      sync   <= '0;
      medida <= '0;
    end else begin
      estado <= prox;
      cnt    <= cnt_n;
      sync   <= {sync[0], echo};
      if (estado == MEDINDO && cm_pronto) medida <= cm_bcd;
    end
  end
  always_comb begin
    prox  = IDLE;
    cnt_n = '0;
    case (estado)
      IDLE:        prox = medir ? DISPARA : IDLE;
      DISPARA: begin
        cnt_n = fim_trig ? '0 : cnt + 1'b1;
        prox  = fim_trig ? ESPERA_ECHO : DISPARA;
      end
      ESPERA_ECHO: begin
        cnt_n = cnt + 1'b1;
        prox  = echo_s ? MEDINDO : fim_tempo ? ERRO : ESPERA_ECHO;
      end
      MEDINDO: begin
        cnt_n = cnt + 1'b1;
        prox  = cm_pronto ? ARMAZENA : fim_tempo ? ERRO : MEDINDO;
      end
      ARMAZENA:    prox = FINAL;
      default:     prox = IDLE;
    endcase
  end
  always_comb begin
    trigger     = estado == DISPARA;
    pulso_cm    = echo_s && estado == MEDINDO;
    pronto      = estado == FINAL || estado == ERRO;
    timeout_err = estado == ERRO;
    db_estado   = estado;
  end
endmodule

// File: tb/tb_hcsr04_medida_ctrl.sv
// tb_hcsr04_medida_ctrl: directed vectors for hcsr04_medida_ctrl with TRIG_CYCLES=4, ECHO_TIMEOUT=40
module tb_hcsr04_medida_ctrl;
  logic        clock = 0, reset = 1, medir = 0, echo = 0, cm_pronto = 0;
  logic [11:0] cm_bcd = '0;
  logic        trigger, pulso_cm, pronto, timeout_err;
  logic [11:0] medida;
  logic [3:0]  db_estado;
  int          vecs = 0, errs = 0;

  hcsr04_medida_ctrl #(.TRIG_CYCLES(4), .ECHO_TIMEOUT(40), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo), .cm_pronto(cm_pronto),
    .cm_bcd(cm_bcd), .trigger(trigger), .pulso_cm(pulso_cm), .medida(medida),
    .pronto(pronto), .timeout_err(timeout_err), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // pulse medir and step to the first cycle of ESPERA_ECHO (counter = 0)
  task automatic start_to_espera();
    medir = 1;
    tick();
    medir = 0;
    tick(4);
  endtask

  initial begin
    int n;
    #1;
    check("rst_estado", db_estado, 0);
    check("rst_trigger", trigger, 0);
    check("rst_outs", {pulso_cm, pronto, timeout_err}, 0);
    check("rst_medida", medida, 12'h000);
    tick();
    reset = 0;
    tick();
    check("idle_hold", db_estado, 0);

    // 1: normal measurement
    medir = 1;
    tick();
    medir = 0;
    check("t1_dispara", db_estado, 1);
    n = 0;
    while (trigger === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("t1_trig_len", 16'(n), 4);
    check("t1_espera", db_estado, 2);
    tick(10);
    echo = 1;
    tick(2);
    check("t1_sync_lag", {db_estado, 3'b0, pulso_cm}, {4'd2, 4'd0});
    tick();
    check("t1_medindo", {db_estado, 3'b0, pulso_cm}, {4'd3, 4'd1});
    tick(4);
    echo = 0;
    tick();
    check("t1_fall_lag1", pulso_cm, 1);
    tick();
    check("t1_fall_lag2", pulso_cm, 0);
    check("t1_still_med", db_estado, 3);
    cm_pronto = 1;
    cm_bcd = 12'h123;
    tick();
    cm_pronto = 0;
    cm_bcd = 12'h999;
    check("t1_armazena", db_estado, 4);
    check("t1_medida_early", medida, 12'h123);
    check("t1_no_pronto", pronto, 0);
    tick();
    check("t1_final", {db_estado, 2'b0, pronto, timeout_err}, {4'd5, 4'b0010});
    check("t1_medida", medida, 12'h123);
    tick();
    check("t1_idle", {db_estado, 2'b0, pronto, timeout_err}, 0);

    // 2: no echo -> ERRO after 40 cycles in ESPERA_ECHO
    start_to_espera();
    check("t2_espera", db_estado, 2);
    tick(39);
    check("t2_last_wait", db_estado, 2);
    tick();
    check("t2_erro", {db_estado, 2'b0, pronto, timeout_err}, {4'd15, 4'b0011});
    check("t2_medida_kept", medida, 12'h123);
    tick();
    check("t2_idle", {db_estado, 2'b0, pronto, timeout_err}, 0);

    // 3: echo present on entry but no count -> timeout on total count
    start_to_espera();
    echo = 1;
    tick(39);
    check("t3_medindo", {db_estado, 3'b0, pulso_cm}, {4'd3, 4'd1});
    tick();
    check("t3_erro", {db_estado, 2'b0, pronto, timeout_err}, {4'd15, 4'b0011});
    check("t3_pulso_drop", pulso_cm, 0);
    echo = 0;
    tick();
    check("t3_idle", db_estado, 0);

    // 4: cm_pronto on the timeout cycle wins
    start_to_espera();
    echo = 1;
    tick(39);
    check("t4_pre", db_estado, 3);
    cm_pronto = 1;
    cm_bcd = 12'h045;
    tick();
    cm_pronto = 0;
    echo = 0;
    check("t4_armazena", db_estado, 4);
    check("t4_medida", medida, 12'h045);
    tick();
    check("t4_final", {db_estado, 2'b0, pronto, timeout_err}, {4'd5, 4'b0010});

    // 5: medir while busy is ignored; held medir retriggers after return to IDLE
    tick();
    medir = 1;
    tick();
    check("t5_dispara", db_estado, 1);
    tick();
    medir = 0;
    tick(3);
    check("t5_espera", db_estado, 2);
    echo = 1;
    tick(3);
    check("t5_medindo", db_estado, 3);
    medir = 1;
    tick();
    medir = 0;
    echo = 0;
    check("t5_busy_med", db_estado, 3);
    cm_pronto = 1;
    tick();
    cm_pronto = 0;
    tick(2);
    check("t5_back_idle", db_estado, 0);
    tick();
    check("t5_not_queued", db_estado, 0);
    check("t5_medida", medida, 12'h045);
    medir = 1;
    tick(5 + 40);
    check("t5_erro", db_estado, 15);
    tick();
    check("t5_idle", db_estado, 0);
    tick();
    check("t5_retrigger", {db_estado, 3'b0, trigger}, {4'd1, 4'd1});
    medir = 0;

    // 6: asynchronous reset in DISPARA and in MEDINDO
    tick();
    check("t6_pre_trig", trigger, 1);
    #2 reset = 1;
    #1;
    check("t6_trig_async", trigger, 0);
    check("t6_estado", db_estado, 0);
    check("t6_medida", medida, 12'h000);
    check("t6_pronto", pronto, 0);
    tick();
    reset = 0;
    start_to_espera();
    echo = 1;
    tick(3);
    check("t6_medindo", db_estado, 3);
    #2 reset = 1;
    #1;
    check("t6b_state", {db_estado, 2'b0, trigger, pulso_cm}, 0);
    tick();
    reset = 0;
    echo = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(pronto);
    end
    check("t6_no_pronto", 16'(n), 0);
    check("t6_idle", db_estado, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
